// File: rtl/booth_pp_stream_pkg.sv
// Shared types for the radix-4 Booth partial-product stream: digit encoding,
// FSM states and the triplet decoder.
package booth_pp_stream_pkg;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_stream_negate.sv
// Combinational two's-complement negator: bits above the lowest set bit are
// inverted, found with a log2-depth prefix-OR network.
module booth_negate #(
    parameter int W = 18
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam int N = W - 1;
    localparam int L = $clog2(N);

    logic [N-1:0] acc;
    logic [N-1:0] stage;

    // After stage s, acc[i] holds OR of x[i : i-2^(s+1)+1]; after L stages, OR of x[i:0].
    always_comb begin
        acc   = x[N-1:0];
        stage = '0;
        for (int unsigned s = 0; s < L; s++) begin
            stage = acc;
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= (32'd1 << s)) begin
                    stage[i] = acc[i] | acc[i - (32'd1 << s)];
                end
            end
            acc = stage;
        end
    end

    assign y = x ^ {acc, 1'b0};

endmodule

// File: rtl/booth_pp_stream.sv
// Sequential radix-4 Booth partial-product generator: latches an operand pair
// and streams one sign-extended partial product per accepted beat.
module booth_pp_stream
    import booth_pp_stream_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int PP_W  = WIDTH + 2,
    localparam int NDIG  = WIDTH / 2 + 1,
    localparam int SH_W  = $clog2(WIDTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PP_W-1:0]   out_pp,
    output logic [SH_W-1:0]   out_shift,
    output logic              out_last
);

    localparam int IDX_W = $clog2(NDIG);

    state_t             state;
    state_t             state_nxt;
    logic [PP_W-1:0]    a_ext;
    logic [WIDTH+2:0]   bx;          // B_ext with the implicit b[-1]=0 at bit 0
    logic               mode_signed;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_idx;
    logic [2:0]         trip;
    logic [PP_W-1:0]    a2;
    logic [PP_W-1:0]    neg_a;
    logic [PP_W-1:0]    neg_a2;
    logic [PP_W-1:0]    pp;
    logic               is_last;
    logic               beat_done;

    assign a2       = {a_ext[PP_W-2:0], 1'b0};
    assign last_idx = mode_signed ? IDX_W'(NDIG - 2) : IDX_W'(NDIG - 1);
    assign trip     = bx[{idx, 1'b0} +: 3];
    assign is_last  = (idx == last_idx);

    booth_negate #(.W(PP_W)) u_neg_a  (.x(a_ext), .y(neg_a));
    booth_negate #(.W(PP_W)) u_neg_a2 (.x(a2),    .y(neg_a2));

    always_comb begin
        pp = '0;
        case (booth_decode(trip))
            POS1:    pp = a_ext;
            POS2:    pp = a2;
            NEG1:    pp = neg_a;
            NEG2:    pp = neg_a2;
            default: pp = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        beat_done = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
                beat_done = out_ready;
                if (abort || (out_ready && is_last)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_ext       <= '0;
            bx          <= '0;
            mode_signed <= 1'b0;
            idx         <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_ext       <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
                bx          <= {(in_signed ? {2{in_b[WIDTH-1]}} : 2'b00), in_b, 1'b0};
                mode_signed <= in_signed;
                idx         <= '0;
            end else if (beat_done) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_pp    = (state == RUN) ? pp : '0;
    assign out_shift = (state == RUN) ? SH_W'({idx, 1'b0}) : '0;
    assign out_last  = (state == RUN) && is_last;

endmodule

// File: tb/tb_booth_pp_stream.sv
// Directed and random-invariant bench for booth_pp_stream (WIDTH=16).
module tb_booth_pp_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_pp;
    logic [4:0]  out_shift;
    logic        out_last;

    int          total = 0;
    int          bad = 0;
    logic [17:0] pp_q [0:8];
    logic [4:0]  sh_q [0:8];
    logic        lst_q [0:8];
    int          nbeats;
    logic [33:0] sum;

    booth_pp_stream #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp),
        .out_shift(out_shift), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Issues one pair at a negedge and collects all beats with out_ready held high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        int   cyc;
        logic got_last;
        nbeats   = 0;
        sum      = '0;
        got_last = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pp_q[i] = 'x; sh_q[i] = 'x; lst_q[i] = 1'bx;
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!got_last && cyc < 40) begin
            if (out_valid) begin
                if (nbeats < 9) begin
                    pp_q[nbeats] = out_pp; sh_q[nbeats] = out_shift; lst_q[nbeats] = out_last;
                end
                sum      = sum + ({{16{out_pp[17]}}, out_pp} << out_shift);
                nbeats   = nbeats + 1;
                got_last = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_last) begin
            total++; bad++;
            $display("FAIL op_timeout a=%h b=%h got=no_last want=last_within_40", a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_pp !== 18'h0)   begin bad++; $display("FAIL reset_out_pp got=%h want=0", out_pp); end
        total++; if (out_shift !== 5'd0) begin bad++; $display("FAIL reset_out_shift got=%0d want=0", out_shift); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_signed_small();
        run_op(16'h0003, 16'h0005, 1'b1);
        total++; if (nbeats !== 8) begin bad++; $display("FAIL small_beats got=%0d want=8", nbeats); end
        total++; if (pp_q[0] !== 18'd3 || sh_q[0] !== 5'd0) begin bad++; $display("FAIL small_pp0 got=%h/%0d want=3/0", pp_q[0], sh_q[0]); end
        total++; if (pp_q[1] !== 18'd3 || sh_q[1] !== 5'd2) begin bad++; $display("FAIL small_pp1 got=%h/%0d want=3/2", pp_q[1], sh_q[1]); end
        for (int i = 2; i < 8; i++) begin
            total++;
            if (pp_q[i] !== 18'd0 || sh_q[i] !== 5'(2 * i)) begin
                bad++; $display("FAIL small_pp%0d got=%h/%0d want=0/%0d", i, pp_q[i], sh_q[i], 2 * i);
            end
        end
        total++; if (lst_q[7] !== 1'b1 || lst_q[6] !== 1'b0) begin bad++; $display("FAIL small_last got=%b%b want=01", lst_q[6], lst_q[7]); end
        total++; if (sum !== 34'd15) begin bad++; $display("FAIL small_sum got=%0d want=15", sum); end
    endtask

    task automatic test_pos2_neg2();
        // B=6: digit0 = -2 (-6), digit1 = +2 (6<<2)
        run_op(16'h0003, 16'h0006, 1'b1);
        total++; if (pp_q[0] !== 18'h3FFFA) begin bad++; $display("FAIL neg2_pp0 got=%h want=3fffa", pp_q[0]); end
        total++; if (pp_q[1] !== 18'h00006) begin bad++; $display("FAIL pos2_pp1 got=%h want=00006", pp_q[1]); end
        total++; if (sum !== 34'd18) begin bad++; $display("FAIL pos2neg2_sum got=%0d want=18", sum); end
    endtask

    task automatic test_min_a();
        run_op(16'h8000, 16'hFFFF, 1'b1);
        total++; if (pp_q[0] !== 18'h08000) begin bad++; $display("FAIL mina_pp0 got=%h want=08000", pp_q[0]); end
        total++; if (pp_q[4] !== 18'h0) begin bad++; $display("FAIL mina_pp4 got=%h want=0", pp_q[4]); end
        total++; if (nbeats !== 8 || lst_q[7] !== 1'b1) begin bad++; $display("FAIL mina_last got=%0d/%b want=8/1", nbeats, lst_q[7]); end
        total++; if (sum !== 34'h0_0000_8000) begin bad++; $display("FAIL mina_sum got=%h want=8000", sum); end
    endtask

    task automatic test_unsigned();
        run_op(16'h0001, 16'hFFFF, 1'b0);
        total++; if (nbeats !== 9) begin bad++; $display("FAIL uns_beats got=%0d want=9", nbeats); end
        total++; if (pp_q[0] !== 18'h3FFFF) begin bad++; $display("FAIL uns_pp0 got=%h want=3ffff", pp_q[0]); end
        total++; if (pp_q[8] !== 18'd1 || sh_q[8] !== 5'd16) begin bad++; $display("FAIL uns_pp8 got=%h/%0d want=1/16", pp_q[8], sh_q[8]); end
        total++; if (sum !== 34'd65535) begin bad++; $display("FAIL uns_sum got=%0d want=65535", sum); end
    endtask

    task automatic test_stall();
        int cyc;
        in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0005; in_signed = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_pp !== 18'd3 || out_shift !== 5'd2 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold c=%0d got=v%b pp%h sh%0d l%b r%b want=v1 pp00003 sh2 l0 r0",
                         c, out_valid, out_pp, out_shift, out_last, in_ready);
            end
        end
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_drain got=%b want=1", in_ready); end
    endtask

    task automatic test_abort();
        int cyc;
        in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0005; in_signed = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out_shift !== 5'd6) begin bad++; $display("FAIL abort_pos got=%0d want=6", out_shift); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=v%b r%b want=v0 r1", out_valid, in_ready); end

        // abort while IDLE does not block acceptance
        abort = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pp !== 18'd3) begin bad++; $display("FAIL abort_in_idle got=v%b pp%h want=v1 pp00003", out_valid, out_pp); end

        // abort coincident with the final handshake
        cyc = 0;
        while (!out_last && cyc < 20) begin @(negedge clk); cyc++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL abort_last got=v%b r%b want=v0 r1", out_valid, in_ready); end

        run_op(16'h0003, 16'h0006, 1'b1);
        total++; if (sum !== 34'd18 || nbeats !== 8) begin bad++; $display("FAIL abort_next got=%0d/%0d want=18/8", sum, nbeats); end
    endtask

    task automatic test_rst_mid();
        in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0005; in_signed = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pp !== 18'h0 || out_shift !== 5'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got=v%b r%b pp%h sh%0d l%b want=v0 r1 pp0 sh0 l0", out_valid, in_ready, out_pp, out_shift, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0003, 16'h0005, 1'b1);
        total++; if (sum !== 34'd15) begin bad++; $display("FAIL rst_next got=%0d want=15", sum); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        longint      av;
        longint      bv;
        longint      prod;
        logic [33:0] want;
        for (int k = 0; k < 2000; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sgn = k[0];
            run_op(a, b, sgn);
            av   = sgn ? longint'($signed(a)) : longint'(a);
            bv   = sgn ? longint'($signed(b)) : longint'(b);
            prod = av * bv;
            want = prod[33:0];
            total++;
            if (sum !== want) begin
                bad++; $display("FAIL rand_sum a=%h b=%h s=%b got=%h want=%h", a, b, sgn, sum, want);
            end
            total++;
            if (nbeats !== (sgn ? 8 : 9)) begin
                bad++; $display("FAIL rand_beats s=%b got=%0d want=%0d", sgn, nbeats, sgn ? 8 : 9);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_small();
        test_pos2_neg2();
        test_min_a();
        test_unsigned();
        test_stall();
        test_abort();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
